dcm_lock_manager: RTL



---
 rtl/dcm_lock_manager.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dcm_lock_manager.sv
// dcm_lock_manager: reset/lock supervisor for NUM_DCM clock managers.
// Each channel pulses its DCM reset, waits for LOCKED with a timeout,
// checks that lock holds for a while, then releases the downstream
// domain reset. If lock fails or is lost, the channel retries; after
// too many failures it latches a fault.
//
// state       | meaning
// ------------+------------------------------------------------------
// S_RST       | DCM held in reset for RST_CYCLES
// S_WAIT_LOCK | DCM released, waiting for synchronised LOCKED
// S_STABLE    | LOCKED seen, counting consecutive locked cycles
// S_RUN       | lock qualified, downstream domain released
// S_FAULT     | retries exhausted, DCM held in reset until restart

module dcm_lock_manager #(
    parameter int NUM_DCM       = 2,
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NUM_DCM-1:0]     dcm_locked,
    input  logic [NUM_DCM-1:0]     restart,
    output logic [NUM_DCM-1:0]     dcm_rst,
    output logic [NUM_DCM-1:0]     domain_rst,
    output logic [NUM_DCM-1:0]     ready,
    output logic [NUM_DCM-1:0]     fault,
    output logic [NUM_DCM-1:0]     lock_lost,
    output logic [4*NUM_DCM-1:0]   retry_cnt
);

    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    for (genvar g = 0; g < NUM_DCM; g++) begin : g_ch
        logic             sync1_q, sync2_q;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [3:0]       retry_q, retry_d;
        logic             fail;
        logic             dcm_rst_q, dcm_rst_d;
        logic             domain_rst_q, domain_rst_d;
        logic             ready_q, ready_d;
        logic             fault_q, fault_d;
        logic             lock_lost_q, lock_lost_d;

        // Two-flop synchroniser for the asynchronous LOCKED input.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= dcm_locked[g];
                sync2_q <= sync1_q;
            end
        end

        // Next-state, counter, retry and output decode for this channel.
        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            retry_d     = retry_q;
            lock_lost_d = 1'b0;
            fail        = 1'b0;

            if (restart[g]) begin
                // Restart overrides everything, including a coincident lock loss.
                state_d = S_RST;
                cnt_d   = '0;
                retry_d = '0;
            end else begin
                case (state_q)
                    S_RST: begin
                        if (cnt_q == RST_LAST) begin
                            state_d = S_WAIT_LOCK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (sync2_q) begin
                            state_d = S_STABLE;
                            cnt_d   = '0;
                        end else if (cnt_q == TIMEOUT_LAST) begin
                            fail = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_STABLE: begin
                        // A drop before qualification is a failed attempt, not a lock loss.
                        if (!sync2_q) begin
                            fail = 1'b1;
                        end else if (cnt_q == STABLE_LAST) begin
                            state_d = S_RUN;
                            cnt_d   = '0;
                            retry_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (!sync2_q) begin
                            lock_lost_d = 1'b1;
                            fail        = 1'b1;
                        end
                    end
                    S_FAULT: begin
                        state_d = S_FAULT;
                    end
                    default: begin
                        state_d = S_RST;
                        cnt_d   = '0;
                    end
                endcase

                if (fail) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RST;
                        if (retry_q != 4'hF) begin
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
            end

            dcm_rst_d    = (state_d == S_RST) || (state_d == S_FAULT);
            domain_rst_d = (state_d != S_RUN);
            ready_d      = (state_d == S_RUN);
            fault_d      = (state_d == S_FAULT);
        end

        // State, counter and registered outputs, all updated on the same edge.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state_q      <= S_RST;
                cnt_q        <= '0;
                retry_q      <= '0;
                dcm_rst_q    <= 1'b1;
                domain_rst_q <= 1'b1;
                ready_q      <= 1'b0;
                fault_q      <= 1'b0;
                lock_lost_q  <= 1'b0;
            end else begin
                state_q      <= state_d;
                cnt_q        <= cnt_d;
                retry_q      <= retry_d;
                dcm_rst_q    <= dcm_rst_d;
                domain_rst_q <= domain_rst_d;
                ready_q      <= ready_d;
                fault_q      <= fault_d;
                lock_lost_q  <= lock_lost_d;
            end
        end

        assign dcm_rst[g]          = dcm_rst_q;
        assign domain_rst[g]       = domain_rst_q;
        assign ready[g]            = ready_q;
        assign fault[g]            = fault_q;
        assign lock_lost[g]        = lock_lost_q;
        assign retry_cnt[4*g +: 4] = retry_q;
    end

endmodule
